// File: rtl/traffic_pkg.sv
// traffic_pkg: shared phase encoding and per-direction lamp bit layout for the traffic controller.
package traffic_pkg;

    typedef enum logic [2:0] {
        GREEN  = 3'd0,
        YELLOW = 3'd1,
        ALLRED = 3'd2,
        WALK   = 3'd3,
        FLASH  = 3'd4
    } state_t;

    localparam int R_B = 2;
    localparam int Y_B = 1;
    localparam int G_B = 0;

    localparam logic [2:0] L_R   = 3'(1 << R_B);
    localparam logic [2:0] L_Y   = 3'(1 << Y_B);
    localparam logic [2:0] L_G   = 3'(1 << G_B);
    localparam logic [2:0] L_OFF = 3'b000;

endpackage

// File: rtl/phase_timer.sv
// phase_timer: dwell counter; done pulses on the tick that completes dur ticks, then the count restarts.
module phase_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             zero,
    input  logic             tick,
    input  logic [CNT_W-1:0] dur,
    output logic             done
);

    logic [CNT_W-1:0] cnt;

    assign done = tick && !zero && cnt == dur - CNT_W'(1);

    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            cnt <= '0;
        else
            cnt <= (zero || done) ? '0 : tick ? cnt + CNT_W'(1) : cnt;
    end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: round-robin signal phasing with pedestrian walk after the last direction
// and a flashing-yellow night mode entered only at an all-red boundary.
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int NUM_DIR  = 2,
    parameter int GREEN_T  = 5,
    parameter int YELLOW_T = 1,
    parameter int ALLRED_T = 1,
    parameter int WALK_T   = 4,
    parameter int CNT_W    = 4
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   tick,
    input  logic                   ped_req,
    input  logic                   night_mode,
    output logic [3*NUM_DIR-1:0]   lights,
    output logic                   walk,
    output logic [1:0]             dir
);

    localparam logic [1:0] LAST = 2'(NUM_DIR - 1);

    state_t               state, state_n;
    logic [1:0]           dir_n;
    logic                 ped_pending, ped_n;
    logic                 flash_phase, flash_n;
    logic                 zero, done;
    logic [CNT_W-1:0]     dur;
    logic [3*NUM_DIR-1:0] lights_n;

    assign dur = state == GREEN  ? CNT_W'(GREEN_T)  :
                 state == YELLOW ? CNT_W'(YELLOW_T) :
                 state == WALK   ? CNT_W'(WALK_T)   : CNT_W'(ALLRED_T);

    phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk  (clk),
        .clr  (clr),
        .zero (zero),
        .tick (tick),
        .dur  (dur),
        .done (done)
    );

    // FLASH and illegal encodings park the timer at zero so the next timed state starts clean.
    always_comb begin
        state_n = state;
        dir_n   = dir;
        flash_n = flash_phase;
        ped_n   = ped_pending | ped_req;
        zero    = 1'b0;
        case (state)
            GREEN:  if (done) state_n = YELLOW;
            YELLOW: if (done) state_n = ALLRED;
            WALK:   if (done) state_n = ALLRED;
            ALLRED: if (done) begin
                if (night_mode) begin
                    state_n = FLASH;
                    dir_n   = LAST;
                    flash_n = 1'b0;
                end else if (ped_pending && dir == LAST) begin
                    state_n = WALK;
                    ped_n   = 1'b0;
                end else begin
                    state_n = GREEN;
                    dir_n   = dir == LAST ? 2'd0 : dir + 2'd1;
                end
            end
            FLASH: begin
                zero = 1'b1;
                if (tick) begin
                    flash_n = ~flash_phase;
                    if (!night_mode) state_n = ALLRED;
                end
            end
            default: begin
                zero    = 1'b1;
                state_n = ALLRED;
            end
        endcase
    end

    // Lamps are decoded from next-state values and registered, so they track the state register exactly.
    for (genvar d = 0; d < NUM_DIR; d++) begin : g_dec
        assign lights_n[3*d +: 3] = state_n == FLASH ? (flash_n ? L_Y : L_OFF) :
                                    (state_n == GREEN  && dir_n == 2'(d)) ? L_G :
                                    (state_n == YELLOW && dir_n == 2'(d)) ? L_Y : L_R;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state       <= ALLRED;
            dir         <= LAST;
            ped_pending <= 1'b0;
            flash_phase <= 1'b0;
            lights      <= {NUM_DIR{L_R}};
            walk        <= 1'b0;
        end else begin
            state       <= state_n;
            dir         <= dir_n;
            ped_pending <= ped_n;
            flash_phase <= flash_n;
            lights      <= lights_n;
            walk        <= state_n == WALK;
        end
    end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb_traffic_phase_ctrl: directed phase sequences plus randomized run against a tick-countdown reference model.
module tb_traffic_phase_ctrl;

    localparam int N  = 2;
    localparam int GT = 5;
    localparam int YT = 1;
    localparam int AT = 1;
    localparam int WT = 4;

    logic       clk = 0, clr = 1, tick = 0, ped_req = 0, night_mode = 0;
    logic [5:0] lights;
    logic       walk;
    logic [1:0] dir;
    int         errors = 0, checks = 0;

    traffic_phase_ctrl #(
        .NUM_DIR(N), .GREEN_T(GT), .YELLOW_T(YT), .ALLRED_T(AT), .WALK_T(WT), .CNT_W(4)
    ) dut (
        .clk(clk), .clr(clr), .tick(tick), .ped_req(ped_req), .night_mode(night_mode),
        .lights(lights), .walk(walk), .dir(dir)
    );

    always #5 clk = ~clk;

    // Reference: phase id (0 G,1 Y,2 AR,3 WALK,4 FLASH) with ticks-remaining countdown.
    int m_ph = 2, m_left = AT, m_dir = N - 1;
    bit m_ped = 0, m_fl = 0, m_np;

    always @(posedge clk or posedge clr) begin
        if (clr) begin
            m_ph = 2; m_left = AT; m_dir = N - 1; m_ped = 0; m_fl = 0;
        end else begin
            m_np = m_ped | ped_req;
            if (tick) begin
                if (m_ph == 4) begin
                    m_fl = !m_fl;
                    if (!night_mode) begin m_ph = 2; m_left = AT; end
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        if (m_ph == 0) begin m_ph = 1; m_left = YT; end
                        else if (m_ph == 1 || m_ph == 3) begin m_ph = 2; m_left = AT; end
                        else if (night_mode) begin m_ph = 4; m_dir = N - 1; m_fl = 0; end
                        else if (m_ped && m_dir == N - 1) begin m_ph = 3; m_left = WT; m_np = 0; end
                        else begin m_ph = 0; m_left = GT; m_dir = (m_dir + 1) % N; end
                    end
                end
            end
            m_ped = m_np;
        end
    end

    function automatic logic [5:0] exp_lights(int ph, int d, bit fl);
        logic [5:0] l;
        for (int i = 0; i < N; i++)
            l[3*i +: 3] = ph == 4 ? (fl ? 3'b010 : 3'b000) :
                          (ph == 0 && d == i) ? 3'b001 :
                          (ph == 1 && d == i) ? 3'b010 : 3'b100;
        return l;
    endfunction

    int inv_nr;
    always @(negedge clk) begin
        if (!clr) begin
            inv_nr = 0;
            for (int i = 0; i < N; i++) if (lights[3*i +: 3] !== 3'b100) inv_nr++;
            checks++;
            if (inv_nr > 1 && lights !== 6'b010010 && lights !== 6'b000000) begin
                errors++;
                $display("FAIL inv_one_green t=%0t lights=%b required at most one non-red", $time, lights);
            end
            checks++;
            if (walk && lights !== 6'b100100) begin
                errors++;
                $display("FAIL inv_walk_red t=%0t lights=%b required 100100 while walk", $time, lights);
            end
        end
    end

    logic [8:0] q[$];

    task automatic push(input logic [5:0] l, input logic w, input logic [1:0] d, input int n);
        repeat (n) q.push_back({w, d, l});
    endtask

    task automatic release_clr();
        clr = 1; tick = 1; ped_req = 0; night_mode = 0;
        repeat (2) @(negedge clk);
        clr = 0;
    endtask

    task automatic test_reset();
        clr = 1; tick = 1;
        repeat (2) @(negedge clk);
        checks++;
        if (lights !== 6'b100100 || walk !== 1'b0 || dir !== 2'd1) begin
            errors++;
            $display("FAIL reset got l=%b w=%b d=%0d required l=100100 w=0 d=1", lights, walk, dir);
        end
    endtask

    task automatic test_sequence();
        release_clr();
        #1;
        checks++;
        if (lights !== 6'b100100 || dir !== 2'd1) begin
            errors++;
            $display("FAIL seq_release got l=%b d=%0d required l=100100 d=1", lights, dir);
        end
        q.delete();
        push(6'b100001, 0, 0, 5); push(6'b100010, 0, 0, 1); push(6'b100100, 0, 0, 1);
        push(6'b001100, 0, 1, 5); push(6'b010100, 0, 1, 1);
        for (int i = 0; i < q.size(); i++) begin
            @(negedge clk);
            checks++;
            if ({walk, dir, lights} !== q[i]) begin
                errors++;
                $display("FAIL seq step %0d got w=%b d=%0d l=%b required %b", i, walk, dir, lights, q[i]);
            end
        end
    endtask

    task automatic test_ped();
        release_clr();
        q.delete();
        push(6'b100001, 0, 0, 5); push(6'b100010, 0, 0, 1); push(6'b100100, 0, 0, 1);
        push(6'b001100, 0, 1, 5); push(6'b010100, 0, 1, 1); push(6'b100100, 0, 1, 1);
        push(6'b100100, 1, 1, 4); push(6'b100100, 0, 1, 1); push(6'b100001, 0, 0, 1);
        for (int i = 0; i < q.size(); i++) begin
            @(negedge clk);
            checks++;
            if ({walk, dir, lights} !== q[i]) begin
                errors++;
                $display("FAIL ped step %0d got w=%b d=%0d l=%b required %b", i, walk, dir, lights, q[i]);
            end
            ped_req = (i == 0);
        end
        ped_req = 0;
    endtask

    task automatic test_slow_tick();
        logic [5:0] prev;
        logic       prev_tick;
        release_clr();
        prev = lights;
        prev_tick = 1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            checks++;
            if (lights !== (k <= 15 ? 6'b100001 : 6'b100010)) begin
                errors++;
                $display("FAIL slow_tick k=%0d got l=%b required %b", k, lights, k <= 15 ? 6'b100001 : 6'b100010);
            end
            if (!prev_tick) begin
                checks++;
                if (lights !== prev) begin
                    errors++;
                    $display("FAIL slow_hold k=%0d got l=%b required %b", k, lights, prev);
                end
            end
            prev = lights;
            tick = (k % 3 == 0);
            prev_tick = tick;
        end
        tick = 1;
    endtask

    task automatic test_night();
        release_clr();
        q.delete();
        push(6'b100001, 0, 0, 5); push(6'b100010, 0, 0, 1); push(6'b100100, 0, 0, 1);
        push(6'b000000, 0, 1, 1); push(6'b010010, 0, 1, 1); push(6'b000000, 0, 1, 1);
        push(6'b010010, 0, 1, 1); push(6'b100100, 0, 1, 1); push(6'b100001, 0, 0, 1);
        for (int i = 0; i < q.size(); i++) begin
            @(negedge clk);
            checks++;
            if ({walk, dir, lights} !== q[i]) begin
                errors++;
                $display("FAIL night step %0d got w=%b d=%0d l=%b required %b", i, walk, dir, lights, q[i]);
            end
            if (i == 1) night_mode = 1;
            if (i == 10) night_mode = 0;
        end
        night_mode = 0;
    endtask

    task automatic test_clr_mid();
        release_clr();
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            ped_req = (i == 0);
        end
        checks++;
        if (lights !== 6'b010100) begin
            errors++;
            $display("FAIL clr_mid_pre got l=%b required 010100", lights);
        end
        #2 clr = 1;
        #1;
        checks++;
        if (lights !== 6'b100100 || walk !== 1'b0 || dir !== 2'd1) begin
            errors++;
            $display("FAIL clr_mid_abort got l=%b w=%b d=%0d required l=100100 w=0 d=1", lights, walk, dir);
        end
        @(negedge clk);
        clr = 0;
        for (int i = 1; i <= 25; i++) begin
            @(negedge clk);
            if (i == 1) begin
                checks++;
                if (lights !== 6'b100001 || dir !== 2'd0) begin
                    errors++;
                    $display("FAIL clr_mid_green got l=%b d=%0d required l=100001 d=0", lights, dir);
                end
            end
            checks++;
            if (walk !== 1'b0) begin
                errors++;
                $display("FAIL clr_mid_walk cycle %0d got walk=%b required 0", i, walk);
            end
        end
    endtask

    task automatic test_random();
        release_clr();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            checks++;
            if (lights !== exp_lights(m_ph, m_dir, m_fl) || walk !== (m_ph == 3) || dir !== 2'(m_dir)) begin
                errors++;
                $display("FAIL random cycle %0d got l=%b w=%b d=%0d required l=%b w=%b d=%0d",
                         i, lights, walk, dir, exp_lights(m_ph, m_dir, m_fl), m_ph == 3, m_dir);
            end
            tick    = $urandom_range(0, 2) != 0;
            ped_req = $urandom_range(0, 15) == 0;
            if ($urandom_range(0, 39) == 0) night_mode = !night_mode;
            clr = clr ? 1'b0 : ($urandom_range(0, 299) == 0);
        end
        clr = 0;
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_ped();
        test_slow_tick();
        test_night();
        test_clr_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
